// File: rtl/uart_tx_sniffer_if.sv
// Byte stream carrying decoded UART bytes from the sniffer to a consumer.
//   m_data  : byte at the FIFO head (valid whenever m_valid is high)
//   m_valid : FIFO non-empty
//   m_ready : consumer takes the head byte when m_valid && m_ready
// master = sniffer side, slave = consumer side.
interface uart_tx_sniffer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_tx_sniffer.sv
// Watches the MCU uart_tx line, decodes 8N1 frames and buffers good bytes in a
// first-word-fall-through FIFO presented on a valid/ready stream.
//   CLK100MHZ  : system clock, rising edge
//   fpga_rst   : synchronous active-high reset
//   uart_tx    : asynchronous serial input, idle high
//   m_if       : byte stream (m_data / m_valid / m_ready)
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overflow   : sticky, a good byte was dropped on a full FIFO
//   busy       : receiver is inside a frame
//   byte_count : good bytes pushed, wraps
module uart_tx_sniffer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               CLK100MHZ,
  input  logic               fpga_rst,
  input  logic               uart_tx,
  uart_tx_sniffer_if.master  m_if,
  output logic               frame_err,
  output logic               overflow,
  output logic               busy,
  output logic [CNT_W-1:0]   byte_count
);

  localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);

  localparam logic [BitCntW-1:0] HalfLast = BitCntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(CLKS_PER_BIT - 1);
  localparam logic [AddrW:0]     DepthVal = (AddrW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Two-flop synchronizer; rxs_q is the only view of the line used below.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_tx;
      rxs_q     <= rx_meta_q;
    end
  end

  logic [1:0]         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               wait_high_q, wait_high_d;
  logic               stop_good, stop_bad;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        // After a framing error the line must go high before a new start counts,
        // so a held break produces one frame_err only.
        if (wait_high_q) begin
          if (rxs_q) wait_high_d = 1'b0;
        end else if (!rxs_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_cnt_q == HalfLast) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? StIdle : StData;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_cnt_q == BitLast) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rxs_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_cnt_q == BitLast) begin
          bit_cnt_d = '0;
          state_d   = StIdle;
          if (rxs_q) begin
            stop_good = 1'b1;
          end else begin
            stop_bad    = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO with one extra pointer bit to tell full from empty.
  logic [7:0]   mem_q [FIFO_DEPTH];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic         fifo_empty, fifo_full, push, pop, ovf_set;
  logic [AddrW:0] fifo_cnt;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_cnt == DepthVal);
  assign pop        = !fifo_empty && m_if.m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = stop_good && (!fifo_full || pop);
  assign ovf_set    = stop_good && fifo_full && !pop;

  logic             frame_err_q, overflow_q;
  logic [CNT_W-1:0] byte_cnt_q;

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      frame_err_q <= stop_bad;
      overflow_q  <= overflow_q | ovf_set;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: it is only visible through the pointers.
  always_ff @(posedge CLK100MHZ) begin
    if (!fpga_rst && push) mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
  end

  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != StIdle);
  assign byte_count   = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_sniffer.sv
module tb_uart_tx_sniffer;
  localparam int unsigned Cpb   = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx  = 1'b1;
  logic frame_err, overflow, busy;
  logic [CntW-1:0] byte_count;

  always #5 clk = ~clk;

  uart_tx_sniffer_if sif ();

  uart_tx_sniffer #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth),
    .CNT_W       (CntW)
  ) dut (
    .CLK100MHZ (clk),
    .fpga_rst  (rst),
    .uart_tx   (tx),
    .m_if      (sif),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy),
    .byte_count(byte_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Accepted bytes and pulse counters, sampled mid-cycle.
  logic [7:0] rx_q[$];
  int valid_cycles = 0;
  int ferr_cycles  = 0;

  always @(negedge clk) begin
    if (sif.m_valid && sif.m_ready) rx_q.push_back(sif.m_data);
    if (sif.m_valid) valid_cycles++;
    if (frame_err) ferr_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Leaves the line at the stop level; the caller restores idle if needed.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    tx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      tx = d[i];
      tick(Cpb);
    end
    tx = stop;
    tick(Cpb);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, vc, fe;
    logic [7:0] exp3 [3];
    logic [7:0] v81;
    exp3[0] = 8'hA5; exp3[1] = 8'h00; exp3[2] = 8'hFF;
    v81 = 8'h81;
    sif.m_ready = 1'b1;
    tick(1);

    // Reset state
    do_reset();
    check_eq("rst_valid", 32'(sif.m_valid), 32'd0);
    check_eq("rst_data", 32'(sif.m_data), 32'h00);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt", 32'(byte_count), 32'd0);

    // Single byte 0x55
    base = rx_q.size(); vc = valid_cycles; fe = ferr_cycles;
    send_frame(8'h55, 1'b1);
    tick(Cpb);
    check_eq("b55_num", 32'(rx_q.size() - base), 32'd1);
    check_eq("b55_data", 32'(rx_q[base]), 32'h55);
    check_eq("b55_vcyc", 32'(valid_cycles - vc), 32'd1);
    check_eq("b55_cnt", 32'(byte_count), 32'd1);
    check_eq("b55_ferr", 32'(ferr_cycles - fe), 32'd0);
    check_eq("b55_busy", 32'(busy), 32'd0);

    // Back-to-back frames
    do_reset();
    base = rx_q.size();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(Cpb);
    check_eq("b2b_num", 32'(rx_q.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) check_eq($sformatf("b2b_data%0d", i), 32'(rx_q[base + i]), 32'(exp3[i]));
    check_eq("b2b_cnt", 32'(byte_count), 32'd3);

    // Overflow with stalled consumer
    do_reset();
    sif.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    tick(4);
    check_eq("ovf_pre", 32'(overflow), 32'd0);
    check_eq("ovf_cnt4", 32'(byte_count), 32'd4);
    send_frame(8'h05, 1'b1);
    tick(4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_cnt", 32'(byte_count), 32'd4);
    check_eq("ovf_valid", 32'(sif.m_valid), 32'd1);
    check_eq("ovf_head", 32'(sif.m_data), 32'h01);
    base = rx_q.size();
    sif.m_ready = 1'b1;
    tick(8);
    check_eq("drain_num", 32'(rx_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("drain_data%0d", i), 32'(rx_q[base + i]), 32'(i + 1));
    check_eq("drain_valid", 32'(sif.m_valid), 32'd0);
    check_eq("drain_ovf", 32'(overflow), 32'd1);
    check_eq("drain_cnt", 32'(byte_count), 32'd4);

    // Two-clock glitch aborts in START
    do_reset();
    base = rx_q.size(); fe = ferr_cycles;
    tx = 1'b0;
    tick(2);
    tx = 1'b1;
    tick(2);
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    tick(4);
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);
    check_eq("glitch_num", 32'(rx_q.size() - base), 32'd0);
    check_eq("glitch_ferr", 32'(ferr_cycles - fe), 32'd0);
    check_eq("glitch_cnt", 32'(byte_count), 32'd0);

    // Framing error followed by a break, then a good frame
    do_reset();
    base = rx_q.size(); fe = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    tick(3 * Cpb);
    tx = 1'b1;
    tick(Cpb);
    check_eq("ferr_pulses", 32'(ferr_cycles - fe), 32'd1);
    check_eq("ferr_num", 32'(rx_q.size() - base), 32'd0);
    check_eq("ferr_cnt", 32'(byte_count), 32'd0);
    send_frame(8'h3C, 1'b1);
    tick(Cpb);
    check_eq("ferr_rearm_num", 32'(rx_q.size() - base), 32'd1);
    check_eq("ferr_rearm_data", 32'(rx_q[base]), 32'h3C);
    check_eq("ferr_rearm_cnt", 32'(byte_count), 32'd1);
    check_eq("ferr_rearm_pulses", 32'(ferr_cycles - fe), 32'd1);

    // Reset during data bit 4 of 0x81
    do_reset();
    sif.m_ready = 1'b0;
    tx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 4; i++) begin
      tx = v81[i];
      tick(Cpb);
    end
    tx = v81[4];
    tick(4);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(2);
    tx  = 1'b1;
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(sif.m_valid), 32'd0);
    check_eq("mid_rst_data", 32'(sif.m_data), 32'h00);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
    check_eq("mid_rst_cnt", 32'(byte_count), 32'd0);
    tick(2 * Cpb);
    check_eq("mid_no_byte", 32'(sif.m_valid), 32'd0);
    send_frame(8'h81, 1'b1);
    tick(4);
    check_eq("mid_new_valid", 32'(sif.m_valid), 32'd1);
    check_eq("mid_new_data", 32'(sif.m_data), 32'h81);
    check_eq("mid_new_cnt", 32'(byte_count), 32'd1);
    tick(2);
    check_eq("mid_hold_data", 32'(sif.m_data), 32'h81);
    sif.m_ready = 1'b1;
    tick(2);
    check_eq("mid_popped", 32'(sif.m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sniffer.md
Name: uart_tx_sniffer

Overview:
- Receive-side companion to the SoC top. Watches the MCU's `uart_tx` serial line on the 100 MHz board clock.
- Decodes 8N1 frames into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream so a checker (bench scoreboard or on-board pass/fail logic) can consume console output without bit-level timing.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the received-byte counter.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- fpga_rst  in  1  synchronous, active-high reset.
- uart_tx  in  1  serial line driven by the MCU; idle high; asynchronous to CLK100MHZ.
- m_data  out  8  byte at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts head when m_valid && m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- busy  out  1  receiver not in IDLE.
- byte_count  out  CNT_W  good bytes pushed into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset (fpga_rst=1 at a clock edge), next cycle:
  - FSM = IDLE; FIFO empty; m_valid=0, m_data=0.
  - frame_err=0, overflow=0, busy=0, byte_count=0.
  - Synchronizer flops = 1.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Input: uart_tx passes a 2-flop synchronizer; `rxs` is the second-flop output. All decisions use rxs.
- bit_cnt counts 0..CLKS_PER_BIT-1. half = CLKS_PER_BIT/2 (integer division).
- IDLE:
  - busy=0.
  - On rxs=0, go to START with bit_cnt=0.
- START:
  - Count to bit_cnt==half-1, then sample rxs.
  - rxs=1: glitch; return to IDLE with no flags.
  - rxs=0: go to DATA with bit_cnt=0, bit_idx=0.
- DATA:
  - At bit_cnt==CLKS_PER_BIT-1, sample rxs into shift[bit_idx]; the LSB is received first.
  - After bit_idx=7, go to STOP.
- STOP: at bit_cnt==CLKS_PER_BIT-1, sample rxs.
  - rxs=1 and FIFO not full: push the byte; byte_count+1.
  - rxs=1 and FIFO full, with no pop in the same cycle: drop the byte; set overflow; byte_count unchanged.
  - rxs=0: frame_err pulses 1 cycle; byte discarded.
  - All cases return to IDLE. If rxs=0, IDLE re-arms only after rxs returns high; a break condition yields a single frame_err, not repeated ones.
- busy=1 in START/DATA/STOP.
- Latency: m_valid rises the cycle after the stop-bit sample edge when the FIFO was empty.
- FIFO:
  - First-word-fall-through; m_data is valid whenever m_valid=1.
  - Pop on m_valid && m_ready.
  - Simultaneous push and pop while full: both occur; no overflow; count unchanged.
  - Simultaneous push and pop while holding 1 entry: m_valid stays 1 and m_data advances to the new byte.
  - Pointers wrap modulo FIFO_DEPTH.
- m_data holds its value while m_valid=1 && m_ready=0.
- overflow is cleared only by reset.
- Back-to-back frames: a start edge arriving while in STOP after the sample point is caught in IDLE on the next cycle. No frame is lost at nominal baud.

Test Plan:
- Reset, CLKS_PER_BIT=8, m_ready=1; send 0x55 with stop=1 -> exactly one m_valid cycle with m_data=0x55, byte_count=1, frame_err=0, busy back to 0.
- Send 0xA5, 0x00, 0xFF back-to-back with no idle gap, m_ready=1 -> bytes out in order 0xA5, 0x00, 0xFF; byte_count=3.
- m_ready=0; send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> overflow=1 after the 5th byte. Then with m_ready=1, drain 0x01..0x04 and m_valid falls; byte_count=4.
- Drive uart_tx low for 2 clocks, then high -> START aborts, no byte output, no frame_err, busy returns to 0 within half a bit.
- Send 0x3C with stop bit 0, then hold the line low for 3 bit times -> single frame_err pulse, no FIFO push, IDLE re-arms after the line goes high. A following 0x3C with stop=1 is received correctly.
- Assert fpga_rst during DATA bit 4 of 0x81 -> after reset all outputs are 0 and no byte appears. A following 0x81 frame yields m_data=0x81 with byte_count=1.
